// File: rtl/ffcp_pkg.sv
// Shared FFCP definitions: packet type codes, default window geometry and the ack FSM state type.
package ffcp_pkg;

  typedef enum logic [1:0] {
    FFCP_SYN = 2'd0,
    FFCP_MSG = 2'd1,
    FFCP_ACK = 2'd2
  } ffcp_type_e;

  localparam int FFCP_INDEX_LEN  = 6;
  localparam int FFCP_WINDOW_LEN = 8;

  typedef enum logic [1:0] {
    ACK_IDLE    = 2'd0,
    ACK_PENDING = 2'd1,
    ACK_SEND    = 2'd2
  } ack_state_e;

endpackage

// File: rtl/ffcp_window_bitmap.sv
// Window-relative receive bitmap: offset compute, accept/dup decode, head advance and bitmap shift.
module ffcp_window_bitmap
  import ffcp_pkg::*;
#(
  parameter int INDEX_LEN  = FFCP_INDEX_LEN,
  parameter int WINDOW_LEN = FFCP_WINDOW_LEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  syn,
  input  logic                  inclk,
  input  logic [INDEX_LEN-1:0]  in_index,
  output logic                  in_accept,
  output logic                  in_dup,
  output logic                  advance,
  output logic [INDEX_LEN-1:0]  head,
  output logic [WINDOW_LEN-1:0] bitmap
);

  localparam int                    DUP_START_I = (1 << INDEX_LEN) - WINDOW_LEN;
  localparam logic [INDEX_LEN-1:0]  DUP_START   = INDEX_LEN'(DUP_START_I);
  localparam logic [INDEX_LEN-1:0]  WIN_LIM     = INDEX_LEN'(WINDOW_LEN);
  localparam logic [WINDOW_LEN-1:0] ONE_HOT     = WINDOW_LEN'(1);

  logic [INDEX_LEN-1:0]  head_r;
  logic [WINDOW_LEN-1:0] bitmap_r;
  logic [INDEX_LEN-1:0]  offset_s;
  logic [WINDOW_LEN-1:0] one_hot_s;
  logic [WINDOW_LEN-1:0] merged_s;
  logic [WINDOW_LEN-1:0] bitmap_next_s;
  logic                  in_window_s;
  logic                  already_s;
  logic                  accept_s;
  logic                  dup_s;

  // Decode the incoming index against the pre-advance head and build the next bitmap.
  always_comb begin
    offset_s      = in_index - head_r;
    in_window_s   = (offset_s < WIN_LIM);
    one_hot_s     = ONE_HOT << offset_s;
    already_s     = |(bitmap_r & one_hot_s);
    accept_s      = 1'b0;
    dup_s         = 1'b0;
    if (inclk && !syn) begin
      accept_s = in_window_s && !already_s;
      dup_s    = (offset_s >= DUP_START);
    end else begin
      accept_s = 1'b0;
      dup_s    = 1'b0;
    end
    merged_s = accept_s ? (bitmap_r | one_hot_s) : bitmap_r;
    // An accept and an advance in the same cycle merge before the shift.
    if (bitmap_r[0]) begin
      bitmap_next_s = merged_s >> 1;
    end else begin
      bitmap_next_s = merged_s;
    end
  end

  // Head and bitmap state; syn restarts the session expecting index 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r   <= {INDEX_LEN{1'b0}};
      bitmap_r <= {WINDOW_LEN{1'b0}};
    end else if (syn) begin
      head_r   <= INDEX_LEN'(1);
      bitmap_r <= {WINDOW_LEN{1'b0}};
    end else begin
      head_r   <= bitmap_r[0] ? head_r + INDEX_LEN'(1) : head_r;
      bitmap_r <= bitmap_next_s;
    end
  end

  assign in_accept = accept_s;
  assign in_dup    = dup_s;
  assign advance   = bitmap_r[0];
  assign head      = head_r;
  assign bitmap    = bitmap_r;

endmodule

// File: rtl/ffcp_rx_window.sv
// FFCP receive window tracker: in-order release plus cumulative ack over valid/ready.
// Define FFCP_SACK_EN to add the ack_sack selective-ack bitmap port.
module ffcp_rx_window
  import ffcp_pkg::*;
#(
  parameter int INDEX_LEN  = FFCP_INDEX_LEN,
  parameter int WINDOW_LEN = FFCP_WINDOW_LEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  syn,
  input  logic                  inclk,
  input  logic [INDEX_LEN-1:0]  in_index,
  output logic                  in_accept,
  output logic                  in_dup,
  output logic                  deliver_clk,
  output logic [INDEX_LEN-1:0]  deliver_index,
  output logic                  ack_valid,
  input  logic                  ack_ready,
`ifdef FFCP_SACK_EN
  output logic [WINDOW_LEN-1:0] ack_sack,
`endif
  output logic [INDEX_LEN-1:0]  ack_index
);

  ack_state_e            state_r;
  logic                  ack_valid_r;
  logic [INDEX_LEN-1:0]  ack_index_r;
  logic                  resend_r;
  logic                  advance_s;
  logic                  dup_s;
  logic                  event_s;
  logic [INDEX_LEN-1:0]  head_s;
  logic [WINDOW_LEN-1:0] bitmap_s;
`ifdef FFCP_SACK_EN
  logic [WINDOW_LEN-1:0] ack_sack_r;
`else
  logic                  sack_unused_s;
`endif

  ffcp_window_bitmap #(
    .INDEX_LEN  (INDEX_LEN),
    .WINDOW_LEN (WINDOW_LEN)
  ) u_bitmap (
    .clk       (clk),
    .rst_n     (rst_n),
    .syn       (syn),
    .inclk     (inclk),
    .in_index  (in_index),
    .in_accept (in_accept),
    .in_dup    (dup_s),
    .advance   (advance_s),
    .head      (head_s),
    .bitmap    (bitmap_s)
  );

  assign event_s = advance_s | dup_s;

  // Ack FSM; the ack is snapshotted when the window is quiet so acks coalesce.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ACK_IDLE;
      ack_valid_r <= 1'b0;
      ack_index_r <= {INDEX_LEN{1'b0}};
      resend_r    <= 1'b0;
`ifdef FFCP_SACK_EN
      ack_sack_r  <= {WINDOW_LEN{1'b0}};
`endif
    end else if (syn) begin
      state_r     <= ACK_PENDING;
      ack_valid_r <= 1'b0;
      resend_r    <= 1'b0;
    end else begin
      case (state_r)
        ACK_IDLE: begin
          if (event_s) begin
            state_r <= ACK_PENDING;
          end else begin
            state_r <= ACK_IDLE;
          end
        end
        ACK_PENDING: begin
          if (!bitmap_s[0] && !inclk) begin
            state_r     <= ACK_SEND;
            ack_valid_r <= 1'b1;
            ack_index_r <= head_s;
`ifdef FFCP_SACK_EN
            ack_sack_r  <= bitmap_s;
`endif
          end else begin
            state_r <= ACK_PENDING;
          end
        end
        ACK_SEND: begin
          // Progress seen while the ack is held must produce a follow-up ack.
          if (ack_ready) begin
            ack_valid_r <= 1'b0;
            resend_r    <= 1'b0;
            state_r     <= (resend_r || event_s) ? ACK_PENDING : ACK_IDLE;
          end else if (event_s) begin
            resend_r <= 1'b1;
          end else begin
            resend_r <= resend_r;
          end
        end
        default: begin
          state_r     <= ACK_IDLE;
          ack_valid_r <= 1'b0;
          resend_r    <= 1'b0;
        end
      endcase
    end
  end

  assign in_dup        = dup_s;
  assign deliver_clk   = advance_s;
  assign deliver_index = head_s;
  assign ack_valid     = ack_valid_r;
  assign ack_index     = ack_index_r;
`ifdef FFCP_SACK_EN
  assign ack_sack      = ack_sack_r;
`else
  assign sack_unused_s = ^bitmap_s;
`endif

endmodule

// File: tb/tb_ffcp_rx_window.sv
// Self-checking bench for ffcp_rx_window: flag table plus scoreboarded deliver/ack sequences.
module tb_ffcp_rx_window;

  localparam int IL = 6;
  localparam int WL = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          syn;
  logic          inclk;
  logic [IL-1:0] in_index;
  logic          in_accept;
  logic          in_dup;
  logic          deliver_clk;
  logic [IL-1:0] deliver_index;
  logic          ack_valid;
  logic          ack_ready;
  logic [IL-1:0] ack_index;
`ifdef FFCP_SACK_EN
  logic [WL-1:0] ack_sack;
`endif

  ffcp_rx_window #(.INDEX_LEN(IL), .WINDOW_LEN(WL)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .syn           (syn),
    .inclk         (inclk),
    .in_index      (in_index),
    .in_accept     (in_accept),
    .in_dup        (in_dup),
    .deliver_clk   (deliver_clk),
    .deliver_index (deliver_index),
    .ack_valid     (ack_valid),
    .ack_ready     (ack_ready),
`ifdef FFCP_SACK_EN
    .ack_sack      (ack_sack),
`endif
    .ack_index     (ack_index)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IL-1:0] idx;
    logic [WL-1:0] sack;
  } ack_exp_t;

  typedef struct {
    logic [IL-1:0] idx;
    logic          acc;
    logic          dup;
    logic          ack;
  } vec_t;

  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            dlv_first = -1;
  int            dlv_last = -1;
  logic [IL-1:0] exp_dlv_q[$];
  ack_exp_t      exp_ack_q[$];
  vec_t          tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: compare every delivery and every ack transfer against the expected queues.
  always @(negedge clk) begin
    cyc++;
    if (rst_n === 1'b1) begin
      if (deliver_clk === 1'b1) begin
        if (exp_dlv_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL deliver_unexpected: got %0d expected none", deliver_index);
        end else begin
          check("deliver_index", 32'(deliver_index), 32'(exp_dlv_q.pop_front()));
          if (dlv_first < 0) dlv_first = cyc;
          dlv_last = cyc;
        end
      end
      if (ack_valid === 1'b1 && ack_ready === 1'b1) begin
        if (exp_ack_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ack_unexpected: got %0d expected none", ack_index);
        end else begin
          ack_exp_t e;
          e = exp_ack_q.pop_front();
          check("ack_index", 32'(ack_index), 32'(e.idx));
`ifdef FFCP_SACK_EN
          check("ack_sack", 32'(ack_sack), 32'(e.sack));
`endif
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [IL-1:0] idx);
    inclk = 1'b1;
    in_index = idx;
    tick();
    inclk = 1'b0;
  endtask

  task automatic send_chk(input logic [IL-1:0] idx, input logic acc, input logic dup);
    inclk = 1'b1;
    in_index = idx;
    #3;
    check("in_accept", 32'(in_accept), 32'(acc));
    check("in_dup", 32'(in_dup), 32'(dup));
    tick();
    inclk = 1'b0;
  endtask

  task automatic push_dlv(input logic [IL-1:0] idx);
    exp_dlv_q.push_back(idx);
  endtask

  task automatic push_ack(input logic [IL-1:0] idx, input logic [WL-1:0] sack);
    ack_exp_t e;
    e.idx = idx;
    e.sack = sack;
    exp_ack_q.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (exp_dlv_q.size() == 0 && exp_ack_q.size() == 0) break;
      tick();
    end
    idle(8);
    check({name, "_dlv_left"}, 32'(exp_dlv_q.size()), 32'd0);
    check({name, "_ack_left"}, 32'(exp_ack_q.size()), 32'd0);
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (ack_valid === 1'b1) break;
      tick();
    end
    check("ack_valid_wait", 32'(ack_valid), 32'd1);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    syn = 1'b0;
    inclk = 1'b0;
    in_index = '0;
    ack_ready = 1'b1;
    idle(2);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{idx: 6'd40, acc: 1'b0, dup: 1'b0, ack: 1'b0};
    tbl[1] = '{idx: 6'd10, acc: 1'b1, dup: 1'b0, ack: 1'b0};
    tbl[2] = '{idx: 6'd10, acc: 1'b0, dup: 1'b0, ack: 1'b0};
    tbl[3] = '{idx: 6'd11, acc: 1'b0, dup: 1'b0, ack: 1'b0};
    tbl[4] = '{idx: 6'd2,  acc: 1'b0, dup: 1'b1, ack: 1'b1};
    tbl[5] = '{idx: 6'd59, acc: 1'b0, dup: 1'b1, ack: 1'b1};
    tbl[6] = '{idx: 6'd58, acc: 1'b0, dup: 1'b0, ack: 1'b0};
    tbl[7] = '{idx: 6'd63, acc: 1'b0, dup: 1'b1, ack: 1'b1};

    rst_n = 1'b0;
    syn = 1'b0;
    inclk = 1'b0;
    in_index = '0;
    ack_ready = 1'b1;
    #12;
    check("rst_ack_valid", 32'(ack_valid), 32'd0);
    check("rst_ack_index", 32'(ack_index), 32'd0);
    check("rst_deliver_clk", 32'(deliver_clk), 32'd0);
    check("rst_deliver_index", 32'(deliver_index), 32'd0);
    check("rst_in_accept", 32'(in_accept), 32'd0);
    check("rst_in_dup", 32'(in_dup), 32'd0);
    reset_dut();

    // In-order 0,1,2: back-to-back delivery and a single coalesced ack of 3.
    push_dlv(6'd0); push_dlv(6'd1); push_dlv(6'd2);
    push_ack(6'd3, 8'h00);
    dlv_first = -1;
    send_chk(6'd0, 1'b1, 1'b0);
    send_chk(6'd1, 1'b1, 1'b0);
    send_chk(6'd2, 1'b1, 1'b0);
    drain("inorder");
    check("inorder_span", 32'(dlv_last - dlv_first), 32'd2);

    // Out-of-order 2,1 holds; 0 then releases all three.
    reset_dut();
    send_chk(6'd2, 1'b1, 1'b0);
    send_chk(6'd1, 1'b1, 1'b0);
    drain("ooo_hold");
    push_dlv(6'd0); push_dlv(6'd1); push_dlv(6'd2);
    push_ack(6'd3, 8'h00);
    dlv_first = -1;
    send_chk(6'd0, 1'b1, 1'b0);
    drain("ooo_release");
    check("ooo_span", 32'(dlv_last - dlv_first), 32'd2);

    // Duplicate re-sends ack 3; out-of-window 40 is silent.
    push_ack(6'd3, 8'h00);
    send_chk(6'd2, 1'b0, 1'b1);
    drain("dup");
    send_chk(6'd40, 1'b0, 1'b0);
    drain("oow");

    // Flag table at head 3; index 10 leaves bit 7 set for later sacks.
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].ack) push_ack(6'd3, 8'h80);
      send_chk(tbl[i].idx, tbl[i].acc, tbl[i].dup);
      idle(6);
    end
    drain("table");

    // Wraparound across 63 -> 0.
    push_ack(6'd2, 8'h00);
    for (int i = 1; i < 64; i++) push_dlv(6'(i));
    push_dlv(6'd0);
    push_dlv(6'd1);
    dlv_first = -1;
    syn = 1'b1;
    tick();
    syn = 1'b0;
    inclk = 1'b1;
    for (int i = 1; i < 64; i++) begin
      in_index = 6'(i);
      tick();
    end
    in_index = 6'd0;
    tick();
    in_index = 6'd1;
    tick();
    inclk = 1'b0;
    drain("wrap");
    check("wrap_span", 32'(dlv_last - dlv_first), 32'd64);

    // Backpressure: ack 3 held while 3,4 arrive, then ack 5 follows.
    reset_dut();
    ack_ready = 1'b0;
    push_dlv(6'd0); push_dlv(6'd1); push_dlv(6'd2);
    send(6'd0); send(6'd1); send(6'd2);
    wait_valid(20);
    check("bp_ack_index_raised", 32'(ack_index), 32'd3);
    push_dlv(6'd3); push_dlv(6'd4);
    send(6'd3); send(6'd4);
    idle(5);
    check("bp_ack_valid_held", 32'(ack_valid), 32'd1);
    check("bp_ack_index_held", 32'(ack_index), 32'd3);
    push_ack(6'd3, 8'h00);
    push_ack(6'd5, 8'h00);
    ack_ready = 1'b1;
    drain("backpressure");

    // Asynchronous reset while an ack is outstanding.
    reset_dut();
    ack_ready = 1'b0;
    push_dlv(6'd0); push_dlv(6'd1);
    send(6'd0); send(6'd1);
    wait_valid(20);
    check("pre_rst_head", 32'(deliver_index), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_ack_valid", 32'(ack_valid), 32'd0);
    check("async_ack_index", 32'(ack_index), 32'd0);
    check("async_head", 32'(deliver_index), 32'd0);
    check("async_deliver_clk", 32'(deliver_clk), 32'd0);
    tick();
    rst_n = 1'b1;
    ack_ready = 1'b1;
    tick();
    push_dlv(6'd0);
    push_ack(6'd1, 8'h00);
    send_chk(6'd0, 1'b1, 1'b0);
    drain("after_reset");

`ifdef FFCP_SACK_EN
    // Selective ack: after syn, 3 and 2 arrive ahead of 1.
    reset_dut();
    push_ack(6'd1, 8'b0000_0110);
    syn = 1'b1;
    tick();
    syn = 1'b0;
    send(6'd3);
    send(6'd2);
    drain("sack_gap");
    push_dlv(6'd1); push_dlv(6'd2); push_dlv(6'd3);
    push_ack(6'd4, 8'h00);
    send(6'd1);
    drain("sack_fill");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
